// File: rtl/premuat_pipe.sv
// Purpose: per-beat premultiply lane permutation (interleave/de-interleave) over 4/8/16/32-lane segments.
// Latency: 1 cycle from input transfer to o_data when the skid buffer is empty or draining.
// Backpressure: 2-entry skid buffer; o_ready depends only on registered occupancy, never on i_ready.
module premuat_pipe #(
    parameter int W = 28,
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic           i_enable,
    input  logic           i_inverse,
    input  logic [1:0]     i_size,
    input  logic           i_last,
    input  logic [N*W-1:0] i_data,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [N*W-1:0] o_data,
    output logic           o_last
);

    typedef struct packed {
        logic           last;
        logic [N*W-1:0] data;
    } beat_t;

    // Source lane for output lane k; segment size is clamped to N so small instances still work.
    function automatic int src_lane(input int k, input int sz, input int inv);
        int n;
        int j;
        int h;
        int s;
        n = 4 << sz;
        if (n > N) n = N;
        j = k % n;
        h = n / 2;
        if (inv != 0) s = (j < h) ? 2 * j : 2 * (j - h) + 1;
        else          s = (j % 2 == 0) ? j / 2 : h + (j - 1) / 2;
        return k - j + s;
    endfunction

    logic [N*W-1:0] perm;

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [W-1:0] fwd [4];
        logic [W-1:0] inv [4];
        for (genvar s = 0; s < 4; s++) begin : g_size
            localparam int SF = src_lane(k, s, 0);
            localparam int SI = src_lane(k, s, 1);
            assign fwd[s] = i_data[SF*W +: W];
            assign inv[s] = i_data[SI*W +: W];
        end
        assign perm[k*W +: W] = !i_enable ? i_data[k*W +: W]
                              : (i_inverse ? inv[i_size] : fwd[i_size]);
    end

    beat_t      head;
    beat_t      tail;
    beat_t      nbeat;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign nbeat   = '{last: i_last, data: perm};
    assign o_ready = (count != 2'd2);
    assign o_valid = (count != 2'd0);
    assign o_data  = head.data;
    assign o_last  = head.last;
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= nbeat;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    // Simultaneous push/pop replaces the head in place, keeping occupancy at one.
                    if (push && pop) begin
                        head <= nbeat;
                    end else if (push) begin
                        tail  <= nbeat;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule
